// File: rtl/memaccess_lsu_pkg.sv
// Shared opcodes, funct3 codes and MA state encoding
// for the memory-access stage.
package memaccess_lsu_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } ma_state_t;

  // Stores and branches never write rd.
  function automatic logic no_rd_write(
    input logic [6:0] opc
  );
    return (opc == OP_STORE) ||
           (opc == OP_BRANCH);
  endfunction

endpackage

// File: rtl/memaccess_align.sv
// Store lane/byte-enable generation, load extract and
// extend, and misaligned / illegal funct3 detection.
module memaccess_align
  import memaccess_lsu_pkg::*;
(
  input  logic [6:0]  opc,
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] rd2,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdat,
  output logic        is_ls,
  output logic        is_st,
  output logic        drop,
  output logic [3:0]  be,
  output logic [31:0] wdat,
  output logic [31:0] ld_dat
);

  logic        is_ld;
  logic        bad;
  logic [31:0] sh;

  assign is_st = (opc == OP_STORE);
  assign is_ld = (opc == OP_LOAD);
  assign is_ls = is_st | is_ld;
  assign drop  = is_ls & bad;

  always_comb begin
    bad  = 1'b1;
    be   = 4'b0000;
    wdat = 32'h0;
    unique case (1'b1)
      is_st && f3 == F3_SB: begin
        bad  = 1'b0;
        be   = 4'b0001 << off;
        wdat = {4{rd2[7:0]}};
      end
      is_st && f3 == F3_SH: begin
        bad  = off[0];
        be   = 4'b0011 << off;
        wdat = {2{rd2[15:0]}};
      end
      is_st && f3 == F3_SW: begin
        bad  = |off;
        be   = 4'b1111;
        wdat = rd2;
      end
      is_ld && (f3 == F3_LB ||
                f3 == F3_LBU): begin
        bad = 1'b0;
        be  = 4'b1111;
      end
      is_ld && (f3 == F3_LH ||
                f3 == F3_LHU): begin
        bad = off[0];
        be  = 4'b1111;
      end
      is_ld && f3 == F3_LW: begin
        bad = |off;
        be  = 4'b1111;
      end
      default: bad = 1'b1;
    endcase
  end

  assign sh = rdat >> {ld_off, 3'b000};

  always_comb begin
    ld_dat = sh;
    unique case (ld_f3)
      F3_LB:   ld_dat = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   ld_dat = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  ld_dat = {24'h0, sh[7:0]};
      F3_LHU:  ld_dat = {16'h0, sh[15:0]};
      default: ld_dat = sh;
    endcase
  end

endmodule

// File: rtl/memaccess_lsu.sv
// Memory-access pipeline stage: ex->ma register, data
// memory req/gnt/rvld sequencing, WB output and forwarding.
module memaccess_lsu
  import memaccess_lsu_pkg::*;
#(
  parameter int          AW       = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ma_vld,
  output logic          ma_rdy,
  input  logic [31:0]   ma_inst,
  input  logic [31:0]   ma_dat,
  input  logic [31:0]   ma_rd2,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_wdat,
  input  logic          dm_gnt,
  input  logic          dm_rvld,
  input  logic [31:0]   dm_rdat,
  output logic          wb_vld,
  input  logic          wb_rdy,
  output logic [31:0]   wb_inst,
  output logic [31:0]   wb_dat,
  output logic          id_fwd_we,
  output logic [4:0]    id_fwd_dst,
  output logic [31:0]   id_fwd_dat,
  output logic          ma_misalign
);

  ma_state_t   state;
  logic [31:0] ls_inst;
  logic [31:0] ls_addr;
  logic        take;
  logic        is_ls;
  logic        is_st;
  logic        drop;
  logic [3:0]  st_be;
  logic [31:0] st_wdat;
  logic [31:0] ld_dat;

  // Only accept when a result produced next cycle
  // has a free WB slot to land in.
  assign ma_rdy = (state == IDLE) &
                  (~wb_vld | wb_rdy);
  assign take   = ma_vld & ma_rdy;

  memaccess_align u_align (
    .opc    (ma_inst[6:0]),
    .f3     (ma_inst[14:12]),
    .off    (ma_dat[1:0]),
    .rd2    (ma_rd2),
    .ld_f3  (ls_inst[14:12]),
    .ld_off (ls_addr[1:0]),
    .rdat   (dm_rdat),
    .is_ls  (is_ls),
    .is_st  (is_st),
    .drop   (drop),
    .be     (st_be),
    .wdat   (st_wdat),
    .ld_dat (ld_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_be       <= '0;
      dm_wdat     <= '0;
      wb_vld      <= 1'b0;
      wb_inst     <= '0;
      wb_dat      <= '0;
      ma_misalign <= 1'b0;
      ls_inst     <= '0;
      ls_addr     <= '0;
    end else begin
      ma_misalign <= 1'b0;
      if (wb_rdy) wb_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            unique case (1'b1)
              !is_ls: begin
                wb_inst <= ma_inst;
                wb_dat  <= ma_dat;
                wb_vld  <= 1'b1;
              end
              drop: begin
                ma_misalign <= 1'b1;
                wb_inst     <= NOP_INST;
                wb_dat      <= '0;
                wb_vld      <= 1'b1;
              end
              default: begin
                ls_inst <= ma_inst;
                ls_addr <= ma_dat;
                dm_req  <= 1'b1;
                dm_we   <= is_st;
                dm_addr <= {ma_dat[AW-1:2], 2'b00};
                dm_be   <= st_be;
                dm_wdat <= st_wdat;
                state   <= REQ;
              end
            endcase
          end
        end
        REQ: begin
          if (dm_gnt) begin
            dm_req <= 1'b0;
            if (dm_we) begin
              wb_inst <= ls_inst;
              wb_dat  <= ls_addr;
              wb_vld  <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dm_rvld) begin
            wb_inst <= ls_inst;
            wb_dat  <= ld_dat;
            wb_vld  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign id_fwd_we  = wb_vld &
                      ~no_rd_write(wb_inst[6:0]) &
                      (wb_inst[11:7] != 5'd0);
  assign id_fwd_dst = wb_inst[11:7];
  assign id_fwd_dat = wb_dat;

endmodule

// File: tb/tb_memaccess_lsu.sv
// Scoreboard bench for memaccess_lsu: random instruction
// stream against a behavioural memory/pipeline model.
module tb_memaccess_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ma_vld = 1'b0;
  logic        ma_rdy;
  logic [31:0] ma_inst = '0;
  logic [31:0] ma_dat = '0;
  logic [31:0] ma_rd2 = '0;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdat;
  logic        dm_gnt = 1'b0;
  logic        dm_rvld = 1'b0;
  logic [31:0] dm_rdat = '0;
  logic        wb_vld;
  logic        wb_rdy = 1'b1;
  logic [31:0] wb_inst;
  logic [31:0] wb_dat;
  logic        id_fwd_we;
  logic [4:0]  id_fwd_dst;
  logic [31:0] id_fwd_dat;
  logic        ma_misalign;

  always #5 clk = ~clk;

  memaccess_lsu #(
    .AW(32),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ma_vld(ma_vld), .ma_rdy(ma_rdy),
    .ma_inst(ma_inst), .ma_dat(ma_dat),
    .ma_rd2(ma_rd2),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdat(dm_wdat), .dm_gnt(dm_gnt),
    .dm_rvld(dm_rvld), .dm_rdat(dm_rdat),
    .wb_vld(wb_vld), .wb_rdy(wb_rdy),
    .wb_inst(wb_inst), .wb_dat(wb_dat),
    .id_fwd_we(id_fwd_we),
    .id_fwd_dst(id_fwd_dst),
    .id_fwd_dat(id_fwd_dat),
    .ma_misalign(ma_misalign)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] dat;
    bit          chk_dat;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdat;
  } bus_exp_t;

  wb_exp_t     exp_wb[$];
  bus_exp_t    exp_bus[$];
  logic [31:0] ref_mem[256];
  logic [31:0] bus_mem[256];

  int nvec = 0;
  int nerr = 0;
  int mis_exp = 0;
  int mis_seen = 0;
  int rdy_mode = 1;
  int gnt_force = -1;
  int rvld_force = -1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s", name);
  endtask

  // Reference model: whole-instruction effect on WB,
  // the memory bus and memory contents.
  task automatic model(input logic [31:0] inst,
                       input logic [31:0] dat,
                       input logic [31:0] rd2);
    wb_exp_t     e;
    bus_exp_t    b;
    int          f3, size, off, idx, nb, v;
    bit          st, legal, aligned;
    logic [31:0] w;
    e.inst = inst;
    e.dat = dat;
    e.chk_dat = 1;
    if (inst[6:0] == 7'h03 || inst[6:0] == 7'h23) begin
      st = (inst[6:0] == 7'h23);
      f3 = int'(inst[14:12]);
      size = f3 % 4;
      off = int'(dat[1:0]);
      idx = int'(dat[9:2]);
      legal = st ? (f3 <= 2) :
              (f3 inside {0, 1, 2, 4, 5});
      aligned = (off % (1 << size)) == 0;
      if (!legal || !aligned) begin
        e.inst = 32'h13;
        e.chk_dat = 0;
        mis_exp++;
      end else begin
        b.addr = dat - 32'(off);
        b.we = st;
        nb = 1 << size;
        b.be = 4'(((1 << nb) - 1) << off);
        if (size == 0)
          b.wdat = (rd2 & 32'hFF) * 32'h0101_0101;
        else if (size == 1)
          b.wdat = (rd2 & 32'hFFFF) * 32'h0001_0001;
        else
          b.wdat = rd2;
        if (st) begin
          for (int k = 0; k < 4; k++)
            if (b.be[k])
              ref_mem[idx][8*k +: 8] = b.wdat[8*k +: 8];
        end else begin
          w = ref_mem[idx] >> (8 * off);
          v = 0;
          if (size == 0) v = int'(w & 32'hFF);
          if (size == 1) v = int'(w & 32'hFFFF);
          if (f3 == 0 && v >= 128) v -= 256;
          if (f3 == 1 && v >= 32768) v -= 65536;
          e.dat = (size == 2) ? w : 32'(v);
        end
        exp_bus.push_back(b);
      end
    end
    exp_wb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after
  // the accepting edge.
  task automatic issue(input logic [31:0] inst,
                       input logic [31:0] dat,
                       input logic [31:0] rd2);
    bit ok = 0;
    ma_inst = inst;
    ma_dat = dat;
    ma_rd2 = rd2;
    ma_vld = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ma_rdy) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) model(inst, dat, rd2);
    else flag("accept_timeout");
    @(posedge clk);
    #1;
    ma_vld = 1'b0;
    ma_inst = $urandom;
  endtask

  task automatic cfg(input int r, input int g,
                     input int v);
    @(negedge clk);
    rdy_mode = r;
    gnt_force = g;
    rvld_force = v;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wb();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wb_vld) return;
    end
    flag("wb_timeout");
  endtask

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: wb_rdy = 1'b1;
      2: wb_rdy = 1'b0;
      default: wb_rdy = ($urandom_range(0, 9) < 7);
    endcase
  end

  // WB monitor / scoreboard checker.
  bit          held = 0;
  logic [31:0] h_inst, h_dat;
  always begin
    wb_exp_t e;
    bit      fw;
    @(negedge clk);
    if (!rst_n) begin
      held = 0;
    end else begin
      if (ma_misalign) mis_seen++;
      if (held) begin
        chk("wb_hold_vld", 32'(wb_vld), 1);
        chk("wb_hold_inst", wb_inst, h_inst);
        chk("wb_hold_dat", wb_dat, h_dat);
      end
      held = 0;
      if (wb_vld && !wb_rdy) begin
        held = 1;
        h_inst = wb_inst;
        h_dat = wb_dat;
      end else if (wb_vld) begin
        if (exp_wb.size() == 0) begin
          flag("wb_unexpected");
        end else begin
          e = exp_wb.pop_front();
          fw = !(e.inst[6:0] inside {7'h23, 7'h63}) &&
               (e.inst[11:7] != 5'd0);
          chk("wb_inst", wb_inst, e.inst);
          if (e.chk_dat) begin
            chk("wb_dat", wb_dat, e.dat);
            chk("fwd_dat", id_fwd_dat, e.dat);
          end
          chk("fwd_we", 32'(id_fwd_we), 32'(fw));
          if (fw)
            chk("fwd_dst", 32'(id_fwd_dst),
                32'(e.inst[11:7]));
        end
      end
    end
  end

  // Data memory responder with its own memory image.
  int          age = 0;
  int          lat = 0;
  int          rd_cnt = 0;
  bit          rd_pend = 0;
  bit          stall = 0;
  logic [31:0] rd_word;
  bus_exp_t    snap;
  always begin
    bus_exp_t b;
    @(posedge clk);
    #1;
    dm_gnt = dm_req &&
             (age >= ((gnt_force >= 0) ? gnt_force : lat));
    if (rd_pend && rd_cnt == 0) begin
      dm_rvld = 1'b1;
      dm_rdat = rd_word;
    end else begin
      dm_rvld = !rd_pend && ($urandom_range(0, 9) == 0);
      dm_rdat = $urandom;
    end
    @(negedge clk);
    if (stall && rst_n) begin
      chk("dm_hold_req", 32'(dm_req), 1);
      chk("dm_hold_addr", dm_addr, snap.addr);
      chk("dm_hold_we", 32'(dm_we), 32'(snap.we));
      chk("dm_hold_be", 32'(dm_be), 32'(snap.be));
      chk("dm_hold_wdat", dm_wdat, snap.wdat);
    end
    stall = 0;
    if (dm_rvld && rd_pend) rd_pend = 0;
    else if (rd_pend) rd_cnt--;
    if (dm_req && dm_gnt && rst_n) begin
      age = 0;
      lat = $urandom_range(0, 3);
      if (exp_bus.size() == 0) begin
        flag("dm_unexpected_req");
      end else begin
        b = exp_bus.pop_front();
        chk("dm_addr", dm_addr, b.addr);
        chk("dm_we", 32'(dm_we), 32'(b.we));
        if (b.we) begin
          chk("dm_be", 32'(dm_be), 32'(b.be));
          chk("dm_wdat", dm_wdat, b.wdat);
        end
      end
      if (dm_we) begin
        for (int k = 0; k < 4; k++)
          if (dm_be[k])
            bus_mem[dm_addr[9:2]][8*k +: 8] =
              dm_wdat[8*k +: 8];
      end else begin
        rd_pend = 1;
        rd_word = bus_mem[dm_addr[9:2]];
        rd_cnt = (rvld_force >= 0) ? rvld_force :
                 $urandom_range(0, 3);
      end
    end else if (dm_req && rst_n) begin
      age++;
      stall = 1;
      snap = '{dm_addr, dm_we, dm_be, dm_wdat};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, inst, dat;
    int          kind, f3, sz;
    logic [6:0]  alu_ops[6];
    alu_ops = '{7'h33, 7'h13, 7'h37, 7'h63,
                7'h6F, 7'h17};
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      ref_mem[i] = w;
      bus_mem[i] = w;
    end

    repeat (3) @(negedge clk);
    chk("rst_dm_req", 32'(dm_req), 0);
    chk("rst_dm_we", 32'(dm_we), 0);
    chk("rst_wb_vld", 32'(wb_vld), 0);
    chk("rst_misalign", 32'(ma_misalign), 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_be", 32'(dm_be), 0);
    chk("rst_dm_wdat", dm_wdat, 0);
    chk("rst_wb_inst", wb_inst, 0);
    chk("rst_wb_dat", wb_dat, 0);
    chk("rst_ma_rdy", 32'(ma_rdy), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU result passes through with latency 1.
    cfg(1, -1, -1);
    issue(32'h0000_02B3, 32'h1234, 32'h0);
    @(negedge clk);
    chk("t1_wb_vld", 32'(wb_vld), 1);
    chk("t1_wb_dat", wb_dat, 32'h1234);
    chk("t1_fwd_we", 32'(id_fwd_we), 1);
    chk("t1_fwd_dst", 32'(id_fwd_dst), 5);
    @(posedge clk);
    #1;

    // SB with a 3-cycle grant delay.
    cfg(1, 3, -1);
    issue(32'h0000_0023, 32'h103, 32'hAABB_CCDD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_req", 32'(dm_req), 1);
      chk("t2_gnt", 32'(dm_gnt), 0);
      chk("t2_addr", dm_addr, 32'h100);
      chk("t2_be", 32'(dm_be), 32'h8);
      chk("t2_wdat", dm_wdat, 32'hDDDD_DDDD);
      chk("t2_ma_rdy", 32'(ma_rdy), 0);
    end
    @(negedge clk);
    chk("t2_gnt_now", 32'(dm_gnt), 1);
    @(negedge clk);
    chk("t2_wb_vld", 32'(wb_vld), 1);
    chk("t2_fwd_we", 32'(id_fwd_we), 0);
    @(posedge clk);
    #1;

    // LB / LBU sign and zero extension.
    cfg(1, -1, -1);
    ref_mem[8'h40] = 32'h0080_0000;
    bus_mem[8'h40] = 32'h0080_0000;
    issue(32'h0000_0303, 32'h102, 32'h0);
    wait_wb();
    chk("t3_lb", wb_dat, 32'hFFFF_FF80);
    @(posedge clk);
    #1;
    issue(32'h0000_4303, 32'h102, 32'h0);
    wait_wb();
    chk("t3_lbu", wb_dat, 32'h0000_0080);
    @(posedge clk);
    #1;

    // Misaligned LW is dropped.
    issue(32'h0000_2383, 32'h202, 32'h0);
    @(negedge clk);
    chk("t4_misalign", 32'(ma_misalign), 1);
    chk("t4_no_req", 32'(dm_req), 0);
    chk("t4_wb_vld", 32'(wb_vld), 1);
    chk("t4_wb_inst", wb_inst, 32'h13);
    chk("t4_fwd_we", 32'(id_fwd_we), 0);
    @(negedge clk);
    chk("t4_pulse_end", 32'(ma_misalign), 0);
    @(posedge clk);
    #1;

    // LW result stalled by WB backpressure.
    ref_mem[8'h41] = 32'hCAFE_F00D;
    bus_mem[8'h41] = 32'hCAFE_F00D;
    cfg(2, -1, -1);
    issue(32'h0000_2483, 32'h104, 32'h0);
    wait_wb();
    for (int i = 0; i < 4; i++) begin
      chk("t5_vld", 32'(wb_vld), 1);
      chk("t5_dat", wb_dat, 32'hCAFE_F00D);
      chk("t5_ma_rdy", 32'(ma_rdy), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cfg(1, -1, -1);

    // Random instruction stream.
    cfg(0, -1, -1);
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      f3 = $urandom_range(0, 7);
      w = $urandom;
      dat = $urandom;
      if (kind < 6) begin
        if ($urandom_range(0, 4) != 0)
          f3 = (kind < 3) ?
               int'($urandom_range(0, 4)) : 0;
        if (kind < 3 && f3 == 3) f3 = 4;
        if (kind < 3 && f3 == 4 &&
            $urandom_range(0, 1) == 0) f3 = 5;
        if (kind >= 3 && f3 > 2 &&
            $urandom_range(0, 4) != 0) f3 = f3 % 3;
        sz = (f3 % 4 == 2) ? 3 : (f3 % 4 == 1) ? 1 : 0;
        dat = $urandom_range(0, 1023);
        if ($urandom_range(0, 3) != 0)
          dat = dat & ~32'(sz);
        inst = {w[31:15], 3'(f3), w[11:7],
                (kind < 3) ? 7'h03 : 7'h23};
      end else begin
        inst = {w[31:15], 3'(f3), w[11:7],
                alu_ops[$urandom_range(0, 5)]};
      end
      issue(inst, dat, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    cfg(1, -1, -1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_wb.size() == 0 && exp_bus.size() == 0)
        break;
    end
    chk("drain_wb", 32'(exp_wb.size()), 0);
    chk("drain_bus", 32'(exp_bus.size()), 0);
    chk("misalign_count", 32'(mis_seen),
        32'(mis_exp));
    @(posedge clk);
    #1;

    // Async reset while a load waits for data.
    cfg(1, 0, 4);
    issue(32'h0000_2503, 32'h108, 32'h0);
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (dm_req && dm_gnt) begin
          seen = 1;
          break;
        end
      end
      if (!seen) flag("t6_no_grant");
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_wb.delete();
    chk("t6_req_drop", 32'(dm_req), 0);
    chk("t6_wb_drop", 32'(wb_vld), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_wb_quiet", 32'(wb_vld), 0);
    end
    chk("t6_idle", 32'(ma_rdy), 1);
    chk("t6_no_req", 32'(dm_req), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
